rca_to_sev: RTL and testbench

- Adds two 4-bit unsigned operands with a 4-stage ripple-carry adder (explicit full-adder chain, carry-in tied to 0).
- Converts the 5-bit sum (0..30) to two BCD digits: seg1 = tens, seg2 = units.
- Registers the digits and drives active-low seven-segment patterns for a two-digit display.
- Sits between the operand switches/stimulus and the board's two-digit display driver.

---
 rtl/rca_to_sev.sv | 126 ++++++++++++
 tb/tb_rca_to_sev.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rca_to_sev.sv
// ----------------------------------------------------------------------------
// rca_to_sev
//
// Adds two 4-bit unsigned operands with an explicit ripple-carry chain, splits
// the 5-bit result (0..30) into BCD tens/units digits, registers sum and
// digits, and decodes each registered digit into an active-low seven-segment
// pattern for a two-digit display.
//
// Ports:
//   clk    in   1  rising-edge system clock
//   rst_n  in   1  asynchronous active-low reset
//   a      in   4  unsigned operand A
//   b      in   4  unsigned operand B
//   seg1   out  4  registered BCD tens digit of a+b (0..3)
//   seg2   out  4  registered BCD units digit of a+b (0..9)
//   sum    out  5  registered binary sum a+b, bit 4 = final carry-out
//   hex1   out  7  active-low segments for seg1, {g,f,e,d,c,b,a}
//   hex2   out  7  active-low segments for seg2, {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module rca_to_sev (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] seg1,
    output logic [3:0] seg2,
    output logic [4:0] sum,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    // ------------------------------------------------------------------------
    // Ripple-carry adder: four chained full adders, carry-in tied low.
    // ------------------------------------------------------------------------
    logic [4:0] w_c;
    logic [3:0] w_s;
    logic [4:0] w_sum;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign w_sum = {w_c[4], w_s};

    // ------------------------------------------------------------------------
    // Binary to BCD split. The sum never exceeds 30, so a three-threshold
    // compare is enough; the units subtraction always lands in 0..9.
    // ------------------------------------------------------------------------
    logic [3:0] w_tens;
    logic [3:0] w_units;

    always_comb begin
        w_tens  = 4'd0;
        w_units = w_sum[3:0];
        if (w_sum >= 5'd30) begin
            w_tens  = 4'd3;
            w_units = 4'(w_sum - 5'd30);
        end else if (w_sum >= 5'd20) begin
            w_tens  = 4'd2;
            w_units = 4'(w_sum - 5'd20);
        end else if (w_sum >= 5'd10) begin
            w_tens  = 4'd1;
            w_units = 4'(w_sum - 5'd10);
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: load every cycle, no enable.
    // ------------------------------------------------------------------------
    logic [4:0] r_sum;
    logic [3:0] r_seg1;
    logic [3:0] r_seg2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 5'd0;
            r_seg1 <= 4'd0;
            r_seg2 <= 4'd0;
        end else begin
            r_sum  <= w_sum;
            r_seg1 <= w_tens;
            r_seg2 <= w_units;
        end
    end

    // ------------------------------------------------------------------------
    // Seven-segment decode, active low, {g,f,e,d,c,b,a}. Codes 10..15 cannot
    // occur but decode to blank so the outputs are always fully defined.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] pat;
        pat = 7'b1111111;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [6:0] w_hex1;
    logic [6:0] w_hex2;

    always_comb begin
        w_hex1 = seg7_decode(r_seg1);
        w_hex2 = seg7_decode(r_seg2);
    end

    assign sum  = r_sum;
    assign seg1 = r_seg1;
    assign seg2 = r_seg2;
    assign hex1 = w_hex1;
    assign hex2 = w_hex2;

endmodule

// File: tb/tb_rca_to_sev.sv
// ----------------------------------------------------------------------------
// tb_rca_to_sev
//
// Directed self-checking bench for rca_to_sev: reset, single-digit and
// decade-boundary sums, mid-cycle input changes, asynchronous reset during
// operation, and a sweep over every operand pair.
// ----------------------------------------------------------------------------
module tb_rca_to_sev;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] seg1;
    logic [3:0] seg2;
    logic [4:0] sum;
    logic [6:0] hex1;
    logic [6:0] hex2;

    int n_checks;
    int n_fail;

    rca_to_sev dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .seg1  (seg1),
        .seg2  (seg2),
        .sum   (sum),
        .hex1  (hex1),
        .hex2  (hex2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference active-low patterns, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] exp_hex(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check all outputs against a hand-computed (tens, units) pair.
    task automatic chk_all(input string tag, input int e_sum, input int e_t, input int e_u);
        chk({tag, " sum"},  32'(sum),  32'(e_sum));
        chk({tag, " seg1"}, 32'(seg1), 32'(e_t));
        chk({tag, " seg2"}, 32'(seg2), 32'(e_u));
        chk({tag, " hex1"}, 32'(hex1), 32'(exp_hex(e_t)));
        chk({tag, " hex2"}, 32'(hex2), 32'(exp_hex(e_u)));
    endtask

    // Apply operands, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [3:0] va, input logic [3:0] vb);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held, operands at max, before any clock edge.
        rst_n = 1'b0;
        a     = 4'd15;
        b     = 4'd15;
        #3;
        chk_all("reset", 0, 0, 0);
        chk("reset hex1 raw", 32'(hex1), 32'h40);

        @(negedge clk);
        rst_n = 1'b1;

        step(4'd0, 4'd1);
        chk_all("0+1", 1, 0, 1);
        step(4'd1, 4'd5);
        chk_all("1+5", 6, 0, 6);
        chk("1+5 hex2 raw", 32'(hex2), 32'h02);
        step(4'd1, 4'd3);
        chk_all("1+3", 4, 0, 4);
        step(4'd2, 4'd9);
        chk_all("2+9", 11, 1, 1);
        chk("2+9 hex1 raw", 32'(hex1), 32'h79);
        step(4'd0, 4'd0);
        chk_all("0+0", 0, 0, 0);
        step(4'd5, 4'd5);
        chk_all("5+5", 10, 1, 0);
        step(4'd12, 4'd8);
        chk_all("12+8", 20, 2, 0);
        step(4'd15, 4'd15);
        chk_all("15+15", 30, 3, 0);
        chk("15+15 sum raw", 32'(sum), 32'b11110);
        chk("15+15 hex1 raw", 32'(hex1), 32'h30);

        // Mid-cycle operand change must not show until the next edge.
        a = 4'd3;
        b = 4'd4;
        @(negedge clk);
        chk_all("latency hold", 30, 3, 0);
        a = 4'd9;
        b = 4'd8;
        #2;
        chk_all("latency hold2", 30, 3, 0);
        @(posedge clk);
        #1;
        chk_all("latency update", 17, 1, 7);

        step(4'd15, 4'd15);
        chk_all("pre-reset", 30, 3, 0);

        // Asynchronous reset between edges clears immediately.
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0);
        @(negedge clk);
        chk_all("reset held", 0, 0, 0);
        rst_n = 1'b1;
        step(4'd0, 4'd1);
        chk_all("post-reset 0+1", 1, 0, 1);

        // Every operand pair.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                step(4'(i), 4'(j));
                chk("sweep sum", 32'(sum), 32'(i + j));
                chk("sweep bcd", 32'(10 * int'(seg1) + int'(seg2)), 32'(i + j));
                chk("sweep units<=9", 32'(seg2 <= 4'd9), 32'd1);
                chk("sweep hex1", 32'(hex1), 32'(exp_hex((i + j) / 10)));
                chk("sweep hex2", 32'(hex2), 32'(exp_hex((i + j) % 10)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
